// File: rtl/reasm_check_joiner_if.sv
// Stream bundle for reasm_check_joiner: packet flits in, metadata words in, joined packet out.
// The slave modport is the joiner's view; master is the view of whatever drives and consumes it.
interface reasm_check_joiner_if #(
    parameter int DWIDTH     = 512,
    parameter int EWIDTH     = 6,
    parameter int META_WIDTH = 256
);
    logic                  in_pkt_valid;
    logic                  in_pkt_ready;
    logic                  in_pkt_sop;
    logic                  in_pkt_eop;
    logic [EWIDTH-1:0]     in_pkt_empty;
    logic [DWIDTH-1:0]     in_pkt_data;
    logic                  in_meta_valid;
    logic                  in_meta_ready;
    logic [META_WIDTH-1:0] in_meta_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sop;
    logic                  out_eop;
    logic [EWIDTH-1:0]     out_empty;
    logic [DWIDTH-1:0]     out_data;
    logic [META_WIDTH-1:0] out_meta;

    modport master (
        output in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_empty, in_pkt_data,
        input  in_pkt_ready,
        output in_meta_valid, in_meta_data,
        input  in_meta_ready,
        input  out_valid, out_sop, out_eop, out_empty, out_data, out_meta,
        output out_ready
    );

    modport slave (
        input  in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_empty, in_pkt_data,
        output in_pkt_ready,
        input  in_meta_valid, in_meta_data,
        output in_meta_ready,
        output out_valid, out_sop, out_eop, out_empty, out_data, out_meta,
        input  out_ready
    );
endinterface

// File: rtl/reasm_check_joiner.sv
// Pairs each reassembled packet with one metadata word (in order, via a meta FIFO) and emits
// a single registered packet stream. Macro REASM_JOIN_STATS_EN enables the stat_* counters.
module reasm_check_joiner #(
    parameter int DWIDTH     = 512,
    parameter int EWIDTH     = 6,
    parameter int META_WIDTH = 256,
    parameter int META_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    reasm_check_joiner_if.slave bus,
    output logic [31:0]         err_sop_cnt,
    output logic [31:0]         stat_pkt_cnt,
    output logic [31:0]         stat_flit_cnt
);

    localparam int          AW         = (META_DEPTH > 1) ? $clog2(META_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C    = (AW+1)'(META_DEPTH);
    localparam logic [AW:0] CNT_ZERO_C = {(AW+1){1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    state_e                state_r;
    state_e                state_nxt_s;
    logic [META_WIDTH-1:0] meta_mem_r [META_DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW:0]           count_r;
    logic                  meta_ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  adv_s;
    logic                  pkt_ready_s;
    logic                  pkt_acc_s;
    logic                  sop_out_s;
    logic                  err_inc_s;
    logic                  out_valid_r;
    logic                  out_sop_r;
    logic                  out_eop_r;
    logic [EWIDTH-1:0]     out_empty_r;
    logic [DWIDTH-1:0]     out_data_r;
    logic [META_WIDTH-1:0] out_meta_r;
    logic [31:0]           err_cnt_r;

    assign adv_s        = ~out_valid_r | bus.out_ready;
    // A full FIFO refuses a push even when the head is popped in the same cycle.
    assign meta_ready_s = (count_r < DEPTH_C);
    assign push_s       = bus.in_meta_valid & meta_ready_s;
    assign pkt_acc_s    = bus.in_pkt_valid & pkt_ready_s;

    assign bus.in_meta_ready = meta_ready_s;
    assign bus.in_pkt_ready  = pkt_ready_s;
    assign bus.out_valid     = out_valid_r;
    assign bus.out_sop       = out_sop_r;
    assign bus.out_eop       = out_eop_r;
    assign bus.out_empty     = out_empty_r;
    assign bus.out_data      = out_data_r;
    assign bus.out_meta      = out_meta_r;
    assign err_sop_cnt       = err_cnt_r;

    // Packet framing state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, flit acceptance, meta pop and sop repair decode.
    always_comb begin
        state_nxt_s = state_r;
        pkt_ready_s = 1'b0;
        pop_s       = 1'b0;
        sop_out_s   = 1'b0;
        err_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pkt_ready_s = adv_s & (count_r != CNT_ZERO_C);
                if (bus.in_pkt_valid & adv_s & (count_r != CNT_ZERO_C)) begin
                    // First flit of a packet always claims the FIFO head and leaves with sop set.
                    pop_s       = 1'b1;
                    sop_out_s   = 1'b1;
                    err_inc_s   = ~bus.in_pkt_sop;
                    state_nxt_s = bus.in_pkt_eop ? ST_IDLE : ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                pkt_ready_s = adv_s;
                if (bus.in_pkt_valid & adv_s) begin
                    sop_out_s   = 1'b0;
                    err_inc_s   = bus.in_pkt_sop;
                    state_nxt_s = bus.in_pkt_eop ? ST_IDLE : ST_STREAM;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Meta FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            meta_mem_r[wr_ptr_r] <= bus.in_meta_data;
        end
    end

    // Meta FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO_C;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Output register: loads on accept, drains when downstream takes the flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            out_empty_r <= {EWIDTH{1'b0}};
            out_data_r  <= {DWIDTH{1'b0}};
            out_meta_r  <= {META_WIDTH{1'b0}};
        end else begin
            if (adv_s) begin
                out_valid_r <= pkt_acc_s;
                if (pkt_acc_s) begin
                    out_sop_r   <= sop_out_s;
                    out_eop_r   <= bus.in_pkt_eop;
                    out_empty_r <= bus.in_pkt_empty;
                    out_data_r  <= bus.in_pkt_data;
                end
            end
            // Metadata changes only at packet start, so it stays stable sop..eop.
            if (pop_s) begin
                out_meta_r <= meta_mem_r[rd_ptr_r];
            end
        end
    end

    // Count of framing errors (missing sop at packet start, or sop inside a packet).
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 32'd0;
        end else if (pkt_acc_s & err_inc_s) begin
            err_cnt_r <= err_cnt_r + 32'd1;
        end
    end

`ifdef REASM_JOIN_STATS_EN
    logic [31:0] stat_pkt_r;
    logic [31:0] stat_flit_r;

    // Output transfer statistics, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkt_r  <= 32'd0;
            stat_flit_r <= 32'd0;
        end else if (out_valid_r & bus.out_ready) begin
            stat_flit_r <= stat_flit_r + 32'd1;
            if (out_eop_r) begin
                stat_pkt_r <= stat_pkt_r + 32'd1;
            end
        end
    end

    assign stat_pkt_cnt  = stat_pkt_r;
    assign stat_flit_cnt = stat_flit_r;
`else
    assign stat_pkt_cnt  = 32'd0;
    assign stat_flit_cnt = 32'd0;
`endif

endmodule
